// File: rtl/bka_mp_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package bka_mp_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index width; a single-word build still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/bka_16.sv
// 16-bit Brent-Kung prefix adder with carry-in and carry-out.
module bka_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_gg;
  logic [15:0] w_pp;
  logic [16:0] w_c;

  always_comb begin
    w_p  = i_a ^ i_b;
    w_g  = i_a & i_b;
    w_pp = w_p;
    w_gg = w_g;
    // Fold carry-in into bit 0 so the prefix tree yields true carries.
    w_gg[0] = w_g[0] | (w_p[0] & i_cin);
    for (int unsigned d = 0; d < 4; d++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (((i + 1) % (2 << d)) == 0) begin
          w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << d)]);
          w_pp[i] = w_pp[i] & w_pp[i - (1 << d)];
        end
      end
    end
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if ((i >= (2 << (2 - k))) && (((i + 1 - (1 << (2 - k))) % (2 << (2 - k))) == 0)) begin
          w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << (2 - k))]);
          w_pp[i] = w_pp[i] & w_pp[i - (1 << (2 - k))];
        end
      end
    end
    w_c    = {w_gg, i_cin};
    o_sum  = w_p ^ w_c[15:0];
    o_cout = w_c[16];
  end

endmodule

// File: rtl/bka_mp_seq.sv
// Multi-precision add/subtract sequencer: one bka_16 walked LSW-first over WORDS words.
// Optional zero/ovf flag outputs when BKA_MP_SEQ_FLAGS_EN is defined.
module bka_mp_seq
  import bka_mp_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   a_in,
  input  logic [WORD_W*WORDS-1:0]   b_in,
  input  logic                      sub,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   q_out,
  output logic                      cout
`ifdef BKA_MP_SEQ_FLAGS_EN
  ,
  output logic                      zero,
  output logic                      ovf
`endif
);

  localparam int unsigned IDX_W = idx_w(WORDS);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [WORDS-1:0][WORD_W-1:0]  r_a;
  logic [WORDS-1:0][WORD_W-1:0]  r_b;
  logic [WORDS-1:0][WORD_W-1:0]  r_q;
  logic                          r_sub;
  logic                          r_carry;
  logic                          r_cout;
  logic [IDX_W-1:0]              r_idx;
  logic [WORD_W-1:0]             w_a_word;
  logic [WORD_W-1:0]             w_b_word;
  logic [WORD_W-1:0]             w_sum;
  logic                          w_cout;
  logic                          w_last;
  logic                          w_accept;

  assign w_a_word = r_a[r_idx];
  assign w_b_word = r_b[r_idx] ^ {WORD_W{r_sub}};
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));
  assign w_accept = (r_state == IDLE) && in_valid;
  assign q_out    = r_q;
  assign cout     = r_cout;

  bka_16 u_bka_16 (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= a_in;
        r_b     <= b_in;
        r_sub   <= sub;
        // Subtraction runs as A + ~B + ~cin, so the initial carry is cin^sub.
        r_carry <= cin ^ sub;
        r_idx   <= '0;
      end
      if (r_state == RUN) begin
        r_q[r_idx] <= w_sum;
        r_carry    <= w_cout;
        if (w_last) r_cout <= w_cout;
        else        r_idx  <= r_idx + 1'b1;
      end
    end
  end

`ifdef BKA_MP_SEQ_FLAGS_EN
  logic r_zero;
  logic r_ovf;
  logic w_c_msb;

  // Carry into the word's MSB, recovered from the MSB sum bit.
  assign w_c_msb = w_a_word[WORD_W-1] ^ w_b_word[WORD_W-1] ^ w_sum[WORD_W-1];
  assign zero    = r_zero;
  assign ovf     = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) r_zero <= 1'b1;
      if (r_state == RUN) begin
        r_zero <= r_zero & (w_sum == '0);
        if (w_last) r_ovf <= w_c_msb ^ w_cout;
      end
    end
  end
`endif

endmodule
